synapse_accumulator: RTL and testbench
======================================

Name: synapse_accumulator

Overview:
- Upstream input stage for the LIF neuron.
- Converts a bundle of binary input spikes into the unsigned 8-bit synaptic current the neuron integrates.
- Each synapse has a programmable weight; active spike weights are summed; the current register leaks exponentially and saturates.
- The `current` output connects directly to the neuron's current input.

Parameters:
- N_SYN, 4: number of input synapses (1..16).
- W_BITS, 8: weight and current width; must match the neuron current width.
- DECAY_SHIFT, 3: leak per update = current >> DECAY_SHIFT, with a minimum leak of 1 when current != 0. Range 0..W_BITS.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  update enable; when low, the entire pipeline holds.
- spike_in  in  N_SYN  input spikes, one bit per synapse, sampled on clk when en=1.
- wr_en  in  1  weight write strobe.
- wr_addr  in  clog2(N_SYN) (min 1)  synapse index to write.
- wr_data  in  W_BITS  weight value.
- current  out  W_BITS  synaptic current to the neuron.
- sat  out  1  high for one cycle when the current update clipped at the upper bound.

Behaviour:
- Reset (reset=1 at a clk edge):
  - All weights cleared to 0; sum_r=0, current=0, sat=0.
  - wr_en is ignored during reset.
  - Reset mid-accumulation discards all state on that edge.
- Weight write:
  - On a clk edge with wr_en=1 and reset=0: weight[wr_addr] <= wr_data.
  - Writes happen regardless of en.
  - wr_addr >= N_SYN: write is ignored.
- Stage 1 (edge k, en=1):
  - sum_r <= sum of weight[i] over all i where spike_in[i]=1.
  - sum_r width is W_BITS+clog2(N_SYN); no overflow is possible.
  - If a write and a spike hit the same synapse in the same cycle, the old weight is used. The new weight applies from the next cycle.
- Stage 2 (same edge, en=1):
  - leak = (current>>DECAY_SHIFT), forced to 1 if that value is 0 and current != 0.
  - nxt = current - leak + sum_r, computed at width W_BITS+clog2(N_SYN)+1.
  - If nxt > 2^W_BITS-1: current <= 2^W_BITS-1 and sat <= 1. Otherwise current <= nxt and sat <= 0.
- Latency:
  - A spike sampled at edge k contributes to current at edge k+1.
  - The contribution is visible on the output after edge k+1.
- en=0:
  - sum_r and current hold; sat <= 0; spike_in is ignored (not buffered).
- DECAY_SHIFT=0: leak equals current, so current <= sat(sum_r), i.e. no memory.
- Empty state: current=0 with no spikes stays 0; no underflow is possible.
- `current` and `sat` are registered outputs; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SYN_INHIBIT_EN.
- Defined:
  - Adds input port wr_inh (1 bit), written alongside the weight into a per-synapse polarity bit inh[i] (reset 0).
  - Stage 1 forms separate exc_sum and inh_sum registers.
  - Stage 2: nxt = current - leak + exc_sum - inh_sum, computed signed.
  - Result clamps at 0 on underflow, with sat unaffected by the lower clamp.
  - Upper clamp and sat behave as in the base block.
- Undefined:
  - No wr_inh port and no polarity storage.
  - All synapses are excitatory, with behaviour exactly as described above.

Test Plan:
1. Reset, then spike_in=4'b1111 for 5 cycles with en=1 -> all weights 0, so current=0 and sat=0 throughout.
2. Write weight[0]=40; pulse spike_in=4'b0001 for one cycle with en=1, then zeros -> current=40 one edge after sampling, then 35, 31, 28, 25 (DECAY_SHIFT=3).
3. Write all weights=200; hold spike_in=4'b1111 -> current=255 and sat=1 on the first update; sat stays 1 while spikes persist and drops to 0 the cycle after spikes stop; current then leaks 255->224.
4. Preload current=7, no spikes -> leak floor gives 6,5,4,3,2,1,0, then current stays 0 with no wrap.
5. Hold en=0 at current=100 and pulse spike_in=4'b0001 -> current holds 100 and the spike is lost. Also write weight[0]=10 and spike the same cycle with en=1 -> the old weight is used.
6. SYN_INHIBIT_EN: weight[1]=50 with inh=1, current=30, spike_in=4'b0010 -> current=0 (30-3-50 clamped) and sat=0. Also reset asserted mid-stream -> current=0 on the next edge.

Source files
------------

// File: rtl/synapse_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : synapse_accumulator
// Description : Weighted spike summation feeding a leaky, saturating 8-bit
//               synaptic current register (LIF neuron input stage).
//               Optional macro SYN_INHIBIT_EN adds per-synapse inhibitory
//               polarity with a lower clamp at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module synapse_accumulator #(
    parameter int N_SYN       = 4,
    parameter int W_BITS      = 8,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  en,
    input  logic [N_SYN-1:0]                      spike_in,
    input  logic                                  wr_en,
    input  logic [((N_SYN > 1) ? $clog2(N_SYN) : 1)-1:0] wr_addr,
    input  logic [W_BITS-1:0]                     wr_data,
`ifdef SYN_INHIBIT_EN
    input  logic                                  wr_inh,
`endif
    output logic [W_BITS-1:0]                     current,
    output logic                                  sat
);

    localparam int ADDR_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;
    localparam int SUM_W  = W_BITS + ADDR_W;
    // Two guard bits: one for the carry of current+sum, one for sign
    localparam int NXT_W  = SUM_W + 2;
    localparam logic [NXT_W-1:0] c_max = {{(NXT_W-W_BITS){1'b0}}, {W_BITS{1'b1}}};

    logic [W_BITS-1:0] r_weight [N_SYN];
    logic [SUM_W-1:0]  r_sum;       // excitatory (or only) stage-1 sum
    logic [W_BITS-1:0] r_current;
    logic              r_sat;

    logic [SUM_W-1:0]  w_sum;
    logic [W_BITS-1:0] w_shift;
    logic [W_BITS-1:0] w_leak;
    logic [NXT_W-1:0]  w_nxt;
    logic              w_over;

`ifdef SYN_INHIBIT_EN
    logic [N_SYN-1:0]  r_inh;
    logic [SUM_W-1:0]  r_inh_sum;
    logic [SUM_W-1:0]  w_inh_sum;
    logic              w_neg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SYN; i++) begin
                r_weight[i] <= '0;
            end
`ifdef SYN_INHIBIT_EN
            r_inh <= '0;
`endif
        end else if (wr_en) begin
            // Addresses outside 0..N_SYN-1 match no entry and are dropped
            for (int i = 0; i < N_SYN; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    r_weight[i] <= wr_data;
`ifdef SYN_INHIBIT_EN
                    r_inh[i]    <= wr_inh;
`endif
                end
            end
        end
    end

    // Summation reads the registered weights, so a same-cycle write is not seen
    always_comb begin
        w_sum = '0;
`ifdef SYN_INHIBIT_EN
        w_inh_sum = '0;
`endif
        for (int i = 0; i < N_SYN; i++) begin
            if (spike_in[i]) begin
`ifdef SYN_INHIBIT_EN
                if (r_inh[i]) begin
                    w_inh_sum = w_inh_sum + SUM_W'(r_weight[i]);
                end else begin
                    w_sum = w_sum + SUM_W'(r_weight[i]);
                end
`else
                w_sum = w_sum + SUM_W'(r_weight[i]);
`endif
            end
        end
    end

    assign w_shift = r_current >> DECAY_SHIFT;
    assign w_leak  = ((w_shift == '0) && (r_current != '0)) ? W_BITS'(1) : w_shift;

`ifdef SYN_INHIBIT_EN
    assign w_nxt  = NXT_W'(r_current) - NXT_W'(w_leak) + NXT_W'(r_sum) - NXT_W'(r_inh_sum);
    assign w_neg  = w_nxt[NXT_W-1];
    assign w_over = !w_neg && (w_nxt > c_max);
`else
    // leak never exceeds current, so this difference cannot go negative
    assign w_nxt  = NXT_W'(r_current) - NXT_W'(w_leak) + NXT_W'(r_sum);
    assign w_over = w_nxt > c_max;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum     <= '0;
            r_current <= '0;
            r_sat     <= 1'b0;
`ifdef SYN_INHIBIT_EN
            r_inh_sum <= '0;
`endif
        end else if (en) begin
            r_sum <= w_sum;
            r_sat <= w_over;
`ifdef SYN_INHIBIT_EN
            r_inh_sum <= w_inh_sum;
            if (w_over) begin
                r_current <= c_max[W_BITS-1:0];
            end else if (w_neg) begin
                r_current <= '0;
            end else begin
                r_current <= w_nxt[W_BITS-1:0];
            end
`else
            r_current <= w_over ? c_max[W_BITS-1:0] : w_nxt[W_BITS-1:0];
`endif
        end else begin
            r_sat <= 1'b0;
        end
    end

    assign current = r_current;
    assign sat     = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_synapse_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_synapse_accumulator
// Description : Directed vector table plus hand sequences for synapse_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synapse_accumulator;

    localparam int N_SYN  = 4;
    localparam int W_BITS = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [N_SYN-1:0]  spike_in;
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic [W_BITS-1:0] wr_data;
    logic              wr_inh;
    logic [W_BITS-1:0] current;
    logic              sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    synapse_accumulator #(
        .N_SYN       (N_SYN),
        .W_BITS      (W_BITS),
        .DECAY_SHIFT (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .spike_in (spike_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
`ifdef SYN_INHIBIT_EN
        .wr_inh   (wr_inh),
`endif
        .current  (current),
        .sat      (sat)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] spk;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [7:0] cur;
        logic       sat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [3:0] s, input logic w,
                       input logic [1:0] a, input logic [7:0] d, input logic [7:0] c,
                       input logic t);
        vec_t v;
        v.rst = r; v.en = e; v.spk = s; v.we = w; v.wa = a; v.wd = d; v.cur = c; v.sat = t;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] s, input logic w,
                         input logic [1:0] a, input logic [7:0] d, input logic i);
        reset = r; en = e; spike_in = s; wr_en = w; wr_addr = a; wr_data = d; wr_inh = i;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int exp_cur;
        int leak;

        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0, 1'b0);

        // Reset, then all-zero weights: spikes produce nothing
        add(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        add(1'b1, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
        // Single spike on weight 40, then exponential leak
        add(1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 8'd40,  8'd0,   1'b0);
        add(1'b0, 1'b1, 4'h1, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd40,  1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd35,  1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd31,  1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd28,  1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd25,  1'b0);
        // Saturation with all weights 200
        add(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        for (int a = 0; a < 4; a++)
            add(1'b0, 1'b0, 4'h0, 1'b1, 2'(a), 8'd200, 8'd0, 1'b0);
        add(1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        add(1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0,   8'd255, 1'b1);
        add(1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0,   8'd255, 1'b1);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd255, 1'b1);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd224, 1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd196, 1'b0);
        // en=0 hold at 100 drops spikes
        add(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 8'd100, 8'd0,   1'b0);
        add(1'b0, 1'b1, 4'h1, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd100, 1'b0);
        add(1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 8'd0,   8'd100, 1'b0);
        add(1'b0, 1'b0, 4'h1, 1'b0, 2'd0, 8'd0,   8'd100, 1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd88,  1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd77,  1'b0);
        // Same-cycle write and spike: old weight 100 is summed, not 10
        add(1'b0, 1'b1, 4'h1, 1'b1, 2'd0, 8'd10,  8'd68,  1'b0);
        add(1'b0, 1'b1, 4'h1, 1'b0, 2'd0, 8'd0,   8'd160, 1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd150, 1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd132, 1'b0);
        // Write during reset is ignored
        add(1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 8'd99,  8'd0,   1'b0);
        add(1'b0, 1'b1, 4'h1, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);
        add(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0,   8'd0,   1'b0);

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].en, tbl[k].spk, tbl[k].we, tbl[k].wa, tbl[k].wd, 1'b0);
            tick();
            check($sformatf("row%0d_current", k), current, tbl[k].cur);
            check($sformatf("row%0d_sat", k), {7'd0, sat}, {7'd0, tbl[k].sat});
        end

        // Leak floor from 7 down to 0, then no wrap
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 8'd7, 1'b0); tick();
        drive(1'b0, 1'b1, 4'h1, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        check("floor_start", current, 8'd7);
        exp_cur = 7;
        for (int i = 0; i < 12; i++) begin
            leak = exp_cur >> 3;
            if (leak == 0 && exp_cur != 0) leak = 1;
            exp_cur = exp_cur - leak;
            tick();
            check($sformatf("floor_step%0d", i), current, 8'(exp_cur));
        end

        // Reset mid-stream discards current, sum and weights
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 8'd60, 1'b0); tick();
        drive(1'b0, 1'b1, 4'h2, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        tick();
        tick();
        check("midrst_before", current, 8'd113);
        drive(1'b1, 1'b1, 4'h2, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        check("midrst_edge", current, 8'd0);
        drive(1'b0, 1'b1, 4'h2, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        check("midrst_after1", current, 8'd0);
        tick();
        check("midrst_after2", current, 8'd0);
        check("midrst_sat", {7'd0, sat}, 8'd0);

`ifdef SYN_INHIBIT_EN
        // Inhibitory synapse drives current below zero -> clamp at 0, no sat
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 8'd30, 1'b0); tick();
        drive(1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 8'd50, 1'b1); tick();
        drive(1'b0, 1'b1, 4'h1, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        drive(1'b0, 1'b1, 4'h2, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        check("inh_pre", current, 8'd30);
        drive(1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0, 1'b0); tick();
        check("inh_clamp", current, 8'd0);
        check("inh_sat", {7'd0, sat}, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
